// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//   Single-controller I2C initiator for a 4-register slave. Each accepted start
//   runs exactly one transaction:
//     write: START, {addr,0}, idx, wdata, STOP
//     read : START, {addr,0}, idx, RESTART, {addr,1}, rx byte + NACK, STOP
//   SCL/SDA are open drain (driven low or released). No clock stretching.
//
// Ports
//   clk       system clock
//   RST_N     asynchronous reset, active low
//   start     transaction request, sampled only while idle
//   rw        0 = write, 1 = read (latched with start)
//   dev_addr  7-bit slave address (latched with start)
//   reg_idx   register index byte (latched with start)
//   wdata     write data byte (latched with start)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse at the end of every transaction
//   ack_err   valid with done: slave NACKed an address/index/data byte
//   rdata     last successfully read byte
//   SCL       open-drain clock
//   SDA       open-drain data, also sampled as input
// -----------------------------------------------------------------------------
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       RST_N,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_idx,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_BYTE    = 3'd2,
    ST_RESTART = 3'd3,
    ST_STOP    = 3'd4
  } state_t;

  state_t          r_state;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;        // quarter within the current bit slot / condition
  logic [3:0]      r_bit;      // 0..7 data slots, 8 = ack slot
  logic [1:0]      r_byte;     // 0 addr(W), 1 idx, 2 wdata or addr(R), 3 rx byte
  logic            r_rw;
  logic [6:0]      r_addr;
  logic [7:0]      r_idx;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rx;
  logic            r_nack;
  logic [7:0]      r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_ack_err;
  logic            r_scl_low;
  logic            r_sda_low;

  state_t          w_state_nxt;
  logic [1:0]      w_q_nxt;
  logic [3:0]      w_bit_nxt;
  logic [1:0]      w_byte_nxt;
  logic            w_accept;
  logic            w_finish;
  logic            w_set_err;
  logic            w_load_rdata;
  logic            w_scl_low;
  logic            w_sda_low;
  logic [7:0]      w_tx_byte;
  logic            w_tick;
  logic            w_sample;
  logic            w_rx_byte;
  logic            w_last_byte;
  logic            w_slot_end;
  logic            w_sda_in;

  assign w_tick      = (r_state != ST_IDLE) && (r_qcnt == QMAX);
  assign w_slot_end  = w_tick && (r_q == 2'd3);
  // SDA is sampled as the machine enters q3 of a data/ack slot
  assign w_sample    = w_tick && (r_q == 2'd2) && (r_state == ST_BYTE);
  assign w_rx_byte   = (r_byte == 2'd3);
  assign w_last_byte = r_rw ? (r_byte == 2'd3) : (r_byte == 2'd2);
  assign w_sda_in    = SDA;

  assign SCL     = r_scl_low ? 1'b0 : 1'bz;
  assign SDA     = r_sda_low ? 1'b0 : 1'bz;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rdata   = r_rdata;

  // Byte currently being shifted out, selected by byte position
  always_comb begin
    w_tx_byte = 8'hFF;
    case (r_byte)
      2'd0:    w_tx_byte = {r_addr, 1'b0};
      2'd1:    w_tx_byte = r_idx;
      2'd2:    w_tx_byte = r_rw ? {r_addr, 1'b1} : r_wdata;
      default: w_tx_byte = 8'hFF;
    endcase
  end

  // Next-state logic and the line levels wanted for the current quarter
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_bit_nxt    = r_bit;
    w_byte_nxt   = r_byte;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_set_err    = 1'b0;
    w_load_rdata = 1'b0;
    w_scl_low    = 1'b0;
    w_sda_low    = 1'b0;

    if (w_tick) begin
      w_q_nxt = r_q + 2'd1;
    end else begin
      w_q_nxt = r_q;
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
          w_q_nxt     = 2'd0;
          w_bit_nxt   = 4'd0;
          w_byte_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_START: begin
        w_scl_low = (r_q == 2'd3);
        w_sda_low = r_q[1];
        if (w_slot_end) begin
          w_state_nxt = ST_BYTE;
          w_bit_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end

      ST_BYTE: begin
        w_scl_low = ~r_q[1];
        // rx data and every ack slot leave SDA released (master NACKs rx byte)
        if ((r_bit < 4'd8) && !w_rx_byte) begin
          w_sda_low = ~w_tx_byte[3'd7 - r_bit[2:0]];
        end else begin
          w_sda_low = 1'b0;
        end
        if (w_slot_end) begin
          if (r_bit == 4'd8) begin
            w_bit_nxt = 4'd0;
            if (!w_rx_byte && r_nack) begin
              w_state_nxt = ST_STOP;
              w_set_err   = 1'b1;
            end else if (r_rw && (r_byte == 2'd1)) begin
              w_state_nxt = ST_RESTART;
              w_byte_nxt  = 2'd2;
            end else if (w_last_byte) begin
              w_state_nxt  = ST_STOP;
              w_load_rdata = w_rx_byte;
            end else begin
              w_byte_nxt = r_byte + 2'd1;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else begin
          w_bit_nxt = r_bit;
        end
      end

      ST_RESTART: begin
        w_scl_low = (r_q == 2'd0) || (r_q == 2'd3);
        w_sda_low = r_q[1];
        if (w_slot_end) begin
          w_state_nxt = ST_BYTE;
          w_bit_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_RESTART;
        end
      end

      ST_STOP: begin
        w_scl_low = (r_q == 2'd0);
        w_sda_low = (r_q != 2'd3);
        if (w_slot_end) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, quarter/bit/byte position and quarter-tick counter
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_qcnt  <= '0;
      r_q     <= 2'd0;
      r_bit   <= 4'd0;
      r_byte  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      if (w_accept || w_tick || (r_state == ST_IDLE)) begin
        r_qcnt <= '0;
      end else begin
        r_qcnt <= r_qcnt + {{(QW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Operand latch, receive shifter and ack sample
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_rw    <= 1'b0;
      r_addr  <= 7'h00;
      r_idx   <= 8'h00;
      r_wdata <= 8'h00;
      r_rx    <= 8'h00;
      r_nack  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw    <= rw;
        r_addr  <= dev_addr;
        r_idx   <= reg_idx;
        r_wdata <= wdata;
      end
      if (w_sample && (r_bit < 4'd8)) begin
        r_rx <= {r_rx[6:0], w_sda_in};
      end
      if (w_sample && (r_bit == 4'd8)) begin
        r_nack <= w_sda_in;
      end
    end
  end

  // Status outputs
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_ack_err <= 1'b0;
      end else if (w_set_err) begin
        r_ack_err <= 1'b1;
      end
      if (w_load_rdata) begin
        r_rdata <= r_rx;
      end
    end
  end

  // Open-drain line drivers. SDA waits until SCL has actually been pulled
  // low before following a change requested together with SCL falling, so a
  // data edge never races the clock edge (would look like START/STOP).
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
    end else begin
      r_scl_low <= w_scl_low;
      if (!w_scl_low || r_scl_low) begin
        r_sda_low <= w_sda_low;
      end
    end
  end

endmodule
